// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    HALT
  } state_t;

  localparam logic [15:0] PC_STEP           = 16'd2;
  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] insn;
  } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO holding fetched words together with their byte address.
// State changes on the falling clock edge, like the rest of the CPU datapath.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  queue_entry_t din,
  output queue_entry_t dout,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  queue_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue and wins over push/pop.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset because count qualifies every read.
  always_ff @(negedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one memory request at a time, buffers the
// returned words in a prefetch queue, handles redirects and stops on the halt word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  input  logic        ir_ready,
  output logic        halted
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [CW-1:0] count;
  queue_entry_t  head;
  queue_entry_t  push_entry;
  logic          push;
  logic          pop;
  logic [15:0]   held_ir;
  logic [15:0]   held_pc;

  assign imem_req  = (state == IDLE) && (count < FULL) && !redirect && reset_n;
  assign imem_addr = fetch_pc;

  assign ir_valid = (count != '0);
  assign ir       = ir_valid ? head.insn : held_ir;
  assign ir_pc    = ir_valid ? head.pc   : held_pc;
  assign pop      = ir_valid && ir_ready;

  // fetch_pc has already advanced past the outstanding request, so step back one.
  assign push            = (state == WAIT) && imem_valid;
  assign push_entry.pc   = fetch_pc - PC_STEP;
  assign push_entry.insn = imem_rdata;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect),
    .din    (push_entry),
    .dout   (head),
    .count  (count)
  );

  // Fetch sequencing: request, wait for response, discard stale responses, halt; redirect overrides all.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[15:1], 1'b0};
      halted   <= 1'b0;
      if (((state == WAIT) || (state == DROP)) && !imem_valid) state <= DROP;
      else                                                      state <= IDLE;
    end else begin
      if (pop && (head.insn == HALT_WORD)) halted <= 1'b1;
      case (state)
        IDLE: begin
          if (imem_req) begin
            state    <= WAIT;
            fetch_pc <= fetch_pc + PC_STEP;
          end
        end
        WAIT: begin
          if (imem_valid) state <= (imem_rdata == HALT_WORD) ? HALT : IDLE;
        end
        DROP: begin
          if (imem_valid) state <= IDLE;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Remember the last presented word so ir stays stable while the queue is empty.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_ir <= 16'h0000;
      held_pc <= 16'h0000;
    end else begin
      held_ir <= ir;
      held_pc <= ir_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        halted;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .HALT_WORD(16'hFFFF)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ir_valid   (ir_valid),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_ready   (ir_ready),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Memory model: image overrides plus a default word that can never be 16'hFFFF at an even address.
  logic [15:0] img [logic [15:0]];
  bit          pend;
  int          pend_cnt;
  logic [15:0] pend_data;
  int          lat;
  bit          rand_lat;
  bit          rand_halt;

  // Reference model state.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] insn;
  } ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc;
  logic [15:0] m_issue_pc;
  logic [15:0] m_last_ir;
  logic [15:0] m_last_pc;
  bit          m_out;
  bit          m_drop;
  bit          m_stop;
  bit          m_halted;

  logic        e_req;
  logic [15:0] e_addr;
  logic        e_valid;
  logic [15:0] e_ir;
  logic [15:0] e_pc;
  logic        e_halted;

  // Observation helpers.
  logic [15:0] req_log[$];
  logic [15:0] watch_word;
  bit          seen_watch;
  int          nreq;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] ir_w;
    logic [15:0] pc;
  } vec_t;
  vec_t tbl[8];
  bit   use_row;
  vec_t row;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (img.exists(a)) return img[a];
    return a ^ 16'h5A3C;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc      = RESET_PC;
    m_out     = 1'b0;
    m_drop    = 1'b0;
    m_stop    = 1'b0;
    m_halted  = 1'b0;
    m_last_ir = 16'h0000;
    m_last_pc = 16'h0000;
  endtask

  task automatic model_step(input logic rd, input logic [15:0] rpc, input logic rdy,
                            input logic mvalid, input logic [15:0] mdata);
    ent_t e;
    m_last_ir = e_ir;
    m_last_pc = e_pc;
    if (rd) begin
      mq.delete();
      m_pc     = rpc & 16'hFFFE;
      m_halted = 1'b0;
      m_stop   = 1'b0;
      if (m_out && !mvalid) begin
        m_out  = 1'b1;
        m_drop = 1'b1;
      end else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
    end else begin
      if (e_valid && rdy) begin
        e = mq.pop_front();
        if (e.insn == 16'hFFFF) m_halted = 1'b1;
      end
      if (m_out && mvalid) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          e.pc   = m_issue_pc;
          e.insn = mdata;
          mq.push_back(e);
          if (mdata == 16'hFFFF) m_stop = 1'b1;
        end
        m_out = 1'b0;
      end
      if (e_req) begin
        m_out      = 1'b1;
        m_issue_pc = m_pc;
        m_pc       = m_pc + 16'd2;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the rising edge, check outputs, advance model and memory.
  task automatic applyStimulus(input logic rst, input logic rd, input logic [15:0] rpc, input logic rdy);
    @(posedge clock);
    cyc++;
    reset_n     = rst;
    redirect    = rd;
    redirect_pc = rpc;
    ir_ready    = rdy;
    imem_valid  = 1'b0;
    imem_rdata  = 16'($urandom);
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = pend_data;
        pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (!rst) model_reset();
    e_req    = rst && !m_out && !m_stop && (mq.size() < DEPTH) && !rd;
    e_addr   = m_pc;
    e_valid  = (mq.size() > 0);
    if (e_valid) begin
      e_ir = mq[0].insn;
      e_pc = mq[0].pc;
    end else begin
      e_ir = m_last_ir;
      e_pc = m_last_pc;
    end
    e_halted = m_halted;
    #1;
    if (use_row) begin
      checkOutput("tbl_req",   16'(imem_req), 16'(row.req));
      checkOutput("tbl_addr",  imem_addr,     row.addr);
      checkOutput("tbl_valid", 16'(ir_valid), 16'(row.valid));
      checkOutput("tbl_ir",    ir,            row.ir_w);
      checkOutput("tbl_ir_pc", ir_pc,         row.pc);
    end else begin
      checkOutput("imem_req",  16'(imem_req), 16'(e_req));
      checkOutput("imem_addr", imem_addr,     e_addr);
      checkOutput("ir_valid",  16'(ir_valid), 16'(e_valid));
      checkOutput("ir",        ir,            e_ir);
      checkOutput("ir_pc",     ir_pc,         e_pc);
    end
    checkOutput("halted", 16'(halted), 16'(e_halted));
    if (ir_valid && (ir == watch_word)) seen_watch = 1'b1;
    if (rst) model_step(rd, rpc, rdy, imem_valid, imem_rdata);
    if (imem_req) begin
      nreq++;
      req_log.push_back(imem_addr);
      pend      = 1'b1;
      pend_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      pend_data = (rand_halt && ($urandom_range(0, 31) == 0)) ? 16'hFFFF : mem_word(imem_addr);
    end
  endtask

  task automatic start_scenario(input int latency);
    img.delete();
    lat        = latency;
    pend       = 1'b0;
    req_log.delete();
    nreq       = 0;
    watch_word = 16'hFFFF;
    seen_watch = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ir_ready    = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = 16'h0000;
    use_row     = 1'b0;
    rand_lat    = 1'b0;
    rand_halt   = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h710F, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 16'h0004, 1'b0, 16'h710F, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h7207, 16'h0002};
    tbl[5] = '{1'b1, 1'b0, 16'h0006, 1'b0, 16'h7207, 16'h0002};
    tbl[6] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h26C0, 16'h0004};
    tbl[7] = '{1'b1, 1'b0, 16'h0008, 1'b0, 16'h26C0, 16'h0004};

    // Streaming with 1-cycle memory and decode always ready.
    start_scenario(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    img[16'h0000] = 16'h710F;
    img[16'h0002] = 16'h7207;
    img[16'h0004] = 16'h26C0;
    use_row = 1'b1;
    for (int i = 0; i < 8; i++) begin
      row = tbl[i];
      applyStimulus(1'b1, 1'b0, 16'h0000, row.rdy);
    end
    use_row = 1'b0;

    // Back-pressure fills the queue, one pop releases exactly one more request.
    start_scenario(1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("full_req_count", 16'(nreq), 16'd2);
    nreq = 0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("refill_req_count", 16'(nreq), 16'd1);
    checkOutput("refill_addr", req_log[req_log.size()-1], 16'h0004);

    // Redirect while a slow response is outstanding: stale word must be dropped.
    start_scenario(3);
    img[16'h0000] = 16'h1234;
    watch_word    = 16'h1234;
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0031, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("stale_word_seen", 16'(seen_watch), 16'd0);
    checkOutput("redirect_addr", (req_log.size() > 1) ? req_log[1] : 16'hDEAD, 16'h0030);

    // Redirect in the same cycle as the response.
    start_scenario(2);
    img[16'h0000] = 16'hABCD;
    watch_word    = 16'hABCD;
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("same_cycle_drop", 16'(seen_watch), 16'd0);
    checkOutput("same_cycle_addr", (req_log.size() > 1) ? req_log[1] : 16'hDEAD, 16'h0100);

    // Halt word at address 16 stops fetch; redirect resumes it.
    start_scenario(1);
    img[16'h0010] = 16'hFFFF;
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("halt_req_count", 16'(nreq), 16'd9);
    checkOutput("halt_last_addr", req_log[req_log.size()-1], 16'h0010);
    checkOutput("halted_set", 16'(halted), 16'd1);
    applyStimulus(1'b1, 1'b1, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("halted_clear", 16'(halted), 16'd0);
    checkOutput("resume_addr", req_log[req_log.size()-1], 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

    // PC wrap at the top of memory, then reset during an outstanding request.
    start_scenario(1);
    applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    lat           = 3;
    img[16'h0000] = 16'hBAD0;
    watch_word    = 16'hBAD0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    img[16'h0000] = 16'h0C0D;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("wrap_first", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'hFFFE);
    checkOutput("wrap_second", (req_log.size() > 1) ? req_log[1] : 16'hDEAD, 16'h0000);
    checkOutput("post_reset_addr", (req_log.size() > 2) ? req_log[2] : 16'hDEAD, RESET_PC);
    checkOutput("late_resp_seen", 16'(seen_watch), 16'd0);

    // Randomized traffic against the reference model.
    start_scenario(1);
    rand_lat  = 1'b1;
    rand_halt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst;
      r_rst = !($urandom_range(0, 199) == 0);
      if (!r_rst) pend = 1'b0;
      applyStimulus(r_rst, ($urandom_range(0, 15) == 0), 16'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
